// File: rtl/led_band_pkg.sv
// rtl/led_band_pkg.sv - shared constants and state type for the LED-band FC receiver
package led_band_pkg;
  localparam int FC_WIDTH = 48;

  // Commands are identified by the number of SCLK posedges seen while LAT is high
  localparam logic [4:0] CMD_WRTGS     = 5'd1;
  localparam logic [4:0] CMD_LATGS     = 5'd3;
  localparam logic [4:0] CMD_WRTFC     = 5'd5;
  localparam logic [4:0] CMD_LINERESET = 5'd7;
  localparam logic [4:0] CMD_READFC    = 5'd11;
  localparam logic [4:0] CMD_TMGRST    = 5'd13;
  localparam logic [4:0] CMD_FCWRTEN   = 5'd15;

  typedef enum logic {RX_IDLE, RX_ARMED} fc_rx_state_t;
endpackage

// File: rtl/led_band_fc_receiver_if.sv
// rtl/led_band_fc_receiver_if.sv - serial line inputs and decoded FC/command outputs
interface led_band_fc_receiver_if;
  import led_band_pkg::*;

  logic                SCLK;
  logic                LAT;
  logic                SIN;
  logic [FC_WIDTH-1:0] fc;
  logic                fc_update;
  logic                fc_armed;
  logic                cmd_valid;
  logic [3:0]          cmd_code;
  logic                cmd_error;

  modport master (
    output SCLK, LAT, SIN,
    input  fc, fc_update, fc_armed, cmd_valid, cmd_code, cmd_error
  );

  modport slave (
    input  SCLK, LAT, SIN,
    output fc, fc_update, fc_armed, cmd_valid, cmd_code, cmd_error
  );
endinterface

// File: rtl/led_band_lat_decoder.sv
// rtl/led_band_lat_decoder.sv - SCLK/LAT edge detection and LAT pulse width counter
module led_band_lat_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       lat,
  output logic       sclk_rise,
  output logic       lat_fall,
  output logic [4:0] width
);
  logic prev_sclk;
  logic prev_lat;

  assign sclk_rise = sclk & ~prev_sclk;
  assign lat_fall  = prev_lat & ~lat;

  // Width is held through the lat_fall sample so the decoder can read it, then cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sclk <= 1'b0;
      prev_lat  <= 1'b0;
      width     <= 5'd0;
    end else begin
      prev_sclk <= sclk;
      prev_lat  <= lat;
      if (lat_fall)
        width <= 5'd0;
      else if (sclk_rise && lat && width != 5'd31)
        width <= width + 5'd1;
    end
  end
endmodule

// File: rtl/led_band_fc_receiver.sv
// rtl/led_band_fc_receiver.sv - LED-band driver-side receiver: command decode and FC commit
module led_band_fc_receiver
  import led_band_pkg::*;
#(
  parameter logic [FC_WIDTH-1:0] DEFAULT_FC = 48'h5c0201008048,
  parameter int                  FC_BITS    = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  led_band_fc_receiver_if.slave  bus
);
  localparam logic [5:0] FC_BITS_CNT = 6'(FC_BITS);

  logic                sclk_rise;
  logic                lat_fall;
  logic [4:0]          width;
  logic                data_bit;
  fc_rx_state_t        state_q, state_d;
  logic [5:0]          bit_cnt, bit_cnt_d, cnt_base;
  logic [FC_WIDTH-1:0] shreg;
  logic [FC_WIDTH-1:0] fc_q;
  logic                clr_cnt, commit, valid_d, err_d;
  logic                fc_update_q, cmd_valid_q, cmd_error_q;
  logic [3:0]          cmd_code_q;

  led_band_lat_decoder u_lat_decoder (
    .clk       (clk),
    .rst       (rst),
    .sclk      (bus.SCLK),
    .lat       (bus.LAT),
    .sclk_rise (sclk_rise),
    .lat_fall  (lat_fall),
    .width     (width)
  );

  assign data_bit = sclk_rise & ~bus.LAT;

  always_comb begin
    state_d = state_q;
    clr_cnt = 1'b0;
    commit  = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (lat_fall) begin
      if (width == 5'd0 || width > 5'd15) begin
        err_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        case (state_q)
          RX_IDLE: begin
            if (width == CMD_FCWRTEN) begin
              state_d = RX_ARMED;
              clr_cnt = 1'b1;
            end else if (width == CMD_WRTFC) begin
              err_d = 1'b1;
            end
          end
          RX_ARMED: begin
            if (width == CMD_FCWRTEN) begin
              clr_cnt = 1'b1;
            end else if (width == CMD_WRTFC) begin
              state_d = RX_IDLE;
              if (bit_cnt == FC_BITS_CNT) commit = 1'b1;
              else                        err_d  = 1'b1;
            end else begin
              state_d = RX_IDLE;
              err_d   = 1'b1;
            end
          end
        endcase
      end
    end

    // A data bit coinciding with lat_fall is counted against the state being entered
    cnt_base  = clr_cnt ? 6'd0 : bit_cnt;
    bit_cnt_d = cnt_base;
    if (data_bit && state_d == RX_ARMED && cnt_base != 6'd63)
      bit_cnt_d = cnt_base + 6'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      bit_cnt     <= 6'd0;
      shreg       <= '0;
      fc_q        <= DEFAULT_FC;
      fc_update_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
      cmd_code_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt     <= bit_cnt_d;
      if (data_bit) shreg <= {shreg[FC_WIDTH-2:0], bus.SIN};
      if (commit)   fc_q  <= shreg;
      fc_update_q <= commit;
      cmd_valid_q <= valid_d;
      cmd_error_q <= err_d;
      if (valid_d)  cmd_code_q <= width[3:0];
    end
  end

  assign bus.fc        = fc_q;
  assign bus.fc_update = fc_update_q;
  assign bus.fc_armed  = (state_q == RX_ARMED);
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.cmd_error = cmd_error_q;
endmodule

// File: tb/tb_led_band_fc_receiver.sv
// tb/tb_led_band_fc_receiver.sv - table, corner-case and randomized checks for led_band_fc_receiver
module tb_led_band_fc_receiver;
  import led_band_pkg::*;

  localparam logic [47:0] DEF = 48'h5c0201008048;
  localparam logic [47:0] VA  = 48'h123456789abc;
  localparam logic [47:0] VB  = 48'hABCDE1234567;
  localparam logic [47:0] VC  = 48'h0f1e2d3c4b5a;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_band_fc_receiver_if bus();

  led_band_fc_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int         n_valid = 0;
  int         n_err   = 0;
  int         n_upd   = 0;
  logic [3:0] last_code = 4'd0;

  always @(negedge clk) begin
    if (bus.cmd_valid) begin
      n_valid   <= n_valid + 1;
      last_code <= bus.cmd_code;
    end
    if (bus.cmd_error) n_err <= n_err + 1;
    if (bus.fc_update) n_upd <= n_upd + 1;
  end

  typedef struct {
    int          nbits;
    logic [63:0] data;
    int          width;
    logic        ev;
    logic        ee;
    logic        eu;
    logic        ea;
    logic [47:0] efc;
  } vec_t;

  vec_t tbl[16];

  logic [47:0] m_fc;
  logic [47:0] m_sr;
  bit          m_armed;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sclk_pulse();
    bus.SCLK = 1'b1;
    wait_clk(2);
    bus.SCLK = 1'b0;
    wait_clk(2);
  endtask

  task automatic send_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.SIN = d[i];
      sclk_pulse();
    end
  endtask

  task automatic do_cmd(input string tag, input int w, input logic ev, input logic ee,
                        input logic eu, input logic ea, input logic [47:0] efc);
    int v0, e0, u0;
    v0 = n_valid;
    e0 = n_err;
    u0 = n_upd;
    bus.LAT = 1'b1;
    wait_clk(2);
    repeat (w) sclk_pulse();
    bus.LAT = 1'b0;
    wait_clk(4);
    check({tag, " cmd_valid"}, 64'(n_valid - v0), 64'(ev));
    check({tag, " cmd_error"}, 64'(n_err - e0), 64'(ee));
    check({tag, " fc_update"}, 64'(n_upd - u0), 64'(eu));
    check({tag, " fc_armed"}, 64'(bus.fc_armed), 64'(ea));
    check({tag, " fc"}, 64'(bus.fc), 64'(efc));
    if (ev) check({tag, " cmd_code"}, 64'(last_code), 64'(w));
  endtask

  task automatic model_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      m_sr = {m_sr[46:0], d[i]};
      if (m_armed) m_cnt++;
    end
  endtask

  task automatic model_cmd(input int w, output logic ev, output logic ee, output logic eu);
    ev = (w >= 1 && w <= 15);
    ee = 1'b0;
    eu = 1'b0;
    if (!ev) begin
      ee = 1'b1;
    end else if (!m_armed) begin
      if (w == 15) begin
        m_armed = 1'b1;
        m_cnt   = 0;
      end else if (w == 5) begin
        ee = 1'b1;
      end
    end else if (w == 15) begin
      m_cnt = 0;
    end else begin
      m_armed = 1'b0;
      if (w == 5 && m_cnt == 48) begin
        m_fc = m_sr;
        eu   = 1'b1;
      end else begin
        ee = 1'b1;
      end
    end
  endtask

  initial begin
    int          widths[13];
    int          w, nb;
    logic [63:0] d;
    logic        ev, ee, eu;

    widths = '{0, 1, 3, 5, 5, 5, 7, 11, 13, 15, 15, 16, 20};

    tbl[0]  = '{0,  64'h0,                5,  1'b1, 1'b1, 1'b0, 1'b0, DEF};
    tbl[1]  = '{0,  64'h0,                20, 1'b0, 1'b1, 1'b0, 1'b0, DEF};
    tbl[2]  = '{0,  64'h0,                15, 1'b1, 1'b0, 1'b0, 1'b1, DEF};
    tbl[3]  = '{48, 64'(VA),              5,  1'b1, 1'b0, 1'b1, 1'b0, VA};
    tbl[4]  = '{0,  64'h0,                15, 1'b1, 1'b0, 1'b0, 1'b1, VA};
    tbl[5]  = '{47, 64'h0000_5555_aaaa_5555, 5, 1'b1, 1'b1, 1'b0, 1'b0, VA};
    tbl[6]  = '{0,  64'h0,                15, 1'b1, 1'b0, 1'b0, 1'b1, VA};
    tbl[7]  = '{49, 64'h0001_0f0f_0f0f_0f0f, 5, 1'b1, 1'b1, 1'b0, 1'b0, VA};
    tbl[8]  = '{0,  64'h0,                15, 1'b1, 1'b0, 1'b0, 1'b1, VA};
    tbl[9]  = '{0,  64'h0,                3,  1'b1, 1'b1, 1'b0, 1'b0, VA};
    tbl[10] = '{0,  64'h0,                15, 1'b1, 1'b0, 1'b0, 1'b1, VA};
    tbl[11] = '{0,  64'h0,                15, 1'b1, 1'b0, 1'b0, 1'b1, VA};
    tbl[12] = '{20, 64'hABCDE,            20, 1'b0, 1'b1, 1'b0, 1'b1, VA};
    tbl[13] = '{28, 64'h1234567,          5,  1'b1, 1'b0, 1'b1, 1'b0, VB};
    tbl[14] = '{0,  64'h0,                7,  1'b1, 1'b0, 1'b0, 1'b0, VB};
    tbl[15] = '{0,  64'h0,                0,  1'b0, 1'b1, 1'b0, 1'b0, VB};

    rst     = 1'b1;
    bus.SCLK = 1'b0;
    bus.LAT  = 1'b0;
    bus.SIN  = 1'b0;
    wait_clk(3);
    check("reset fc", 64'(bus.fc), 64'(DEF));
    check("reset fc_armed", 64'(bus.fc_armed), 64'd0);
    check("reset pulses", 64'({bus.cmd_valid, bus.cmd_error, bus.fc_update}), 64'd0);
    check("reset cmd_code", 64'(bus.cmd_code), 64'd0);
    rst = 1'b0;
    wait_clk(2);

    for (int i = 0; i < 16; i++) begin
      send_bits(tbl[i].data, tbl[i].nbits);
      do_cmd($sformatf("vec%0d", i), tbl[i].width, tbl[i].ev, tbl[i].ee,
             tbl[i].eu, tbl[i].ea, tbl[i].efc);
    end

    // Asynchronous reset in the middle of a frame
    do_cmd("midrst arm", 15, 1'b1, 1'b0, 1'b0, 1'b1, VB);
    send_bits(64'(VA), 20);
    #2;
    rst = 1'b1;
    #1;
    check("midrst fc", 64'(bus.fc), 64'(DEF));
    check("midrst fc_armed", 64'(bus.fc_armed), 64'd0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    do_cmd("post arm", 15, 1'b1, 1'b0, 1'b0, 1'b1, DEF);
    send_bits(64'(VC), 48);
    do_cmd("post wrtfc", 5, 1'b1, 1'b0, 1'b1, 1'b0, VC);

    m_fc    = VC;
    m_sr    = VC;
    m_armed = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      nb = ($urandom_range(0, 2) == 0) ? 48 : int'($urandom_range(0, 52));
      d  = {$urandom, $urandom};
      w  = widths[$urandom_range(0, 12)];
      send_bits(d, nb);
      model_bits(d, nb);
      model_cmd(w, ev, ee, eu);
      do_cmd($sformatf("rnd%0d w%0d b%0d", i, w, nb), w, ev, ee, eu, m_armed, m_fc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_band_fc_receiver.md
Name: led_band_fc_receiver

Overview:
- Driver-side receiver for the LED-band serial control protocol: the counterpart of the FC setter.
- Oversamples SCLK/LAT/SIN in the clk domain and decodes commands from the LAT pulse width (number of SCLK posedges while LAT is high).
- Collects the 48-bit function-control (FC) word shifted MSB first between FCWRTEN and WRTFC, and commits it on WRTFC.
- Used as an in-fabric driver model for loopback checking of the setter/sync modules and as a bench scoreboard source.

Parameters:
- DEFAULT_FC, 48'h5c0201008048, value loaded into fc on reset.
- FC_BITS, 48, exact number of SIN bits required between FCWRTEN and WRTFC.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- SCLK  input  1  serial clock, already synchronous to clk
- LAT  input  1  latch/command line, synchronous to clk
- SIN  input  1  serial data, sampled on SCLK posedge
- fc  output  48  committed FC register
- fc_update  output  1  one-cycle pulse when fc is written
- fc_armed  output  1  high between a valid FCWRTEN and the following command
- cmd_valid  output  1  one-cycle pulse per decoded LAT command
- cmd_code  output  4  LAT width of the last command (SCLK posedges counted while LAT was high)
- cmd_error  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (async, rst=1): fc=DEFAULT_FC; fc_update=cmd_valid=cmd_error=0; cmd_code=0; fc_armed=0; shift register=0; bit counter=0; LAT width counter=0; prev_SCLK=prev_LAT=0; state=IDLE.
- Edge detection: posedge_SCLK = SCLK & ~prev_SCLK. lat_fall = prev_LAT & ~LAT. Both are evaluated on the current clk sample.
- On posedge_SCLK with LAT=1: the 5-bit width counter increments and saturates at 31.
- On posedge_SCLK with LAT=0: SIN is shifted into bit 0 of the 48-bit shift register, so the oldest bit ends at bit 47 (MSB first). In ARMED, the 6-bit bit counter increments and saturates at 63.
- The width counter clears on the cycle after lat_fall, not while LAT is low. This lets the decode read it.
- Decode on the lat_fall cycle; all outputs are registered and visible one clk later:
  - Width w in 1..15: cmd_valid=1, cmd_code=w.
  - Width 0 or >15: cmd_error=1, no cmd_valid, state is unchanged.
- FSM, two states:
  - IDLE, w=15 (FCWRTEN): go to ARMED, clear the bit counter, fc_armed=1.
  - IDLE, w=5 (WRTFC): writes are locked. cmd_valid only; fc is unchanged; cmd_error=1.
  - ARMED, w=5 with bit counter == FC_BITS: fc <= shift register, fc_update=1, go to IDLE.
  - ARMED, w=5 with bit counter != FC_BITS: cmd_error=1, fc is unchanged, go to IDLE.
  - ARMED, w=15: re-arm and clear the bit counter (no error).
  - ARMED, any other valid w: abort to IDLE with cmd_error=1.
- Simultaneous events:
  - SCLK posedge on the same sample LAT rises: counted as a width edge, not shifted.
  - SCLK posedge on the lat_fall sample: treated as a LAT-low data bit. It shifts into the register and is counted from the next state.
- Other codes (1,3,7,11,13) are reported via cmd_valid/cmd_code only; no internal effect.
- Reset mid-frame: everything returns to reset values immediately. fc reverts to DEFAULT_FC.

Decomposition:
- Package led_band_pkg holds:
  - FC_WIDTH=48.
  - Command-width constants: CMD_WRTGS=1, CMD_LATGS=3, CMD_WRTFC=5, CMD_LINERESET=7, CMD_READFC=11, CMD_TMGRST=13, CMD_FCWRTEN=15.
  - typedef enum logic {RX_IDLE, RX_ARMED} fc_rx_state_t.
- One sub-module, led_band_lat_decoder: SCLK/LAT edge detection, width counter with saturation, lat_fall strobe and width output. The FC shift/commit FSM stays in the top.

Test Plan:
- After reset: fc=48'h5c0201008048, all pulses 0, fc_armed=0.
- Legal write: FCWRTEN (LAT high 15 SCLK), then 48 SCLK shifting 48'h123456789abc MSB first, then WRTFC (5 SCLK). Required: cmd_valid with code 15, then code 5; fc_update one cycle; fc=48'h123456789abc; fc_armed falls.
- Short frame (47 bits) or long frame (49 bits) before WRTFC: cmd_error pulse, fc unchanged, state IDLE.
- WRTFC without a prior FCWRTEN: cmd_valid with code 5 plus cmd_error; fc unchanged.
- LAT high for 20 SCLK: cmd_error, no cmd_valid. LAT high for 3 SCLK while ARMED: cmd_valid with code 3, cmd_error, fc_armed=0.
- rst asserted after 20 of 48 bits: asynchronous return to defaults. A full legal sequence afterwards commits correctly.
